// File: rtl/uart_rx_frame.sv
// Oversampling UART receive front end: start-bit glitch filter, 3-sample
// majority vote per bit, LSB-first data, optional parity and stop-bit checks.
module uart_rx_frame #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic [5:0]       prescale,
    input  logic             parity_enable,
    input  logic             parity_type,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             parity_error,
    output logic             stop_error
);

    localparam int              BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [5:0]       r_p;
    logic             r_par_en;
    logic             r_par_type;
    logic [5:0]       r_edge_cnt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [2:0]       r_smp;
    logic [WIDTH-1:0] r_shift;
    logic             r_par_fail;
    logic [WIDTH-1:0] r_p_data;
    logic             r_data_valid;
    logic             r_parity_error;
    logic             r_stop_error;

    logic [5:0]       w_p_sel;
    logic [5:0]       w_half;
    logic             w_last_edge;
    logic             w_start_det;
    logic             w_maj;
    logic             w_exp_par;
    logic             w_dv_d;
    logic             w_perr_d;
    logic             w_serr_d;

    // Unsupported oversampling ratios fall back to 8.
    always_comb begin
        case (prescale)
            6'd16:   w_p_sel = 6'd16;
            6'd32:   w_p_sel = 6'd32;
            default: w_p_sel = 6'd8;
        endcase
    end

    assign w_half      = r_p >> 1;
    assign w_last_edge = (r_edge_cnt == (r_p - 6'd1));
    assign w_start_det = (r_state == S_IDLE) && !RX_IN;
    assign w_maj       = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    assign w_exp_par   = r_par_type ? ~^r_shift : ^r_shift;

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves the target unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_last_edge) begin
                    w_next_state = w_maj ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_edge && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last_edge) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last_edge) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Result decode at the stop bit's commit edge; registered below.
    always_comb begin
        w_dv_d   = 1'b0;
        w_perr_d = 1'b0;
        w_serr_d = 1'b0;
        if ((r_state == S_STOP) && w_last_edge) begin
            w_serr_d = !w_maj;
            w_perr_d = r_par_fail;
            w_dv_d   = !r_par_fail && w_maj;
        end
    end

    // Datapath: counters, samples, shift register, flags and registered outputs.
    always_ff @(posedge CLK) begin
        // NOTE: every register is reset explicitly; there is no array storage here.
        if (RST) begin
            r_p            <= 6'd8;
            r_par_en       <= 1'b0;
            r_par_type     <= 1'b0;
            r_edge_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_smp          <= '0;
            r_shift        <= '0;
            r_par_fail     <= 1'b0;
            r_p_data       <= '0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
        end else begin
            r_data_valid   <= w_dv_d;
            r_parity_error <= w_perr_d;
            r_stop_error   <= w_serr_d;
            if (w_dv_d) begin
                r_p_data <= r_shift;
            end

            // The start-detect cycle is edge 0, so the START state begins at edge 1.
            if (r_state == S_IDLE) begin
                r_edge_cnt <= w_start_det ? 6'd1 : 6'd0;
                r_bit_cnt  <= '0;
            end else begin
                r_edge_cnt <= w_last_edge ? 6'd0 : (r_edge_cnt + 6'd1);
            end

            if (w_start_det) begin
                r_p        <= w_p_sel;
                r_par_en   <= parity_enable;
                r_par_type <= parity_type;
                r_par_fail <= 1'b0;
            end

            if (r_state != S_IDLE) begin
                if (r_edge_cnt == (w_half - 6'd1)) r_smp[0] <= RX_IN;
                if (r_edge_cnt == w_half)          r_smp[1] <= RX_IN;
                if (r_edge_cnt == (w_half + 6'd1)) r_smp[2] <= RX_IN;
            end

            if ((r_state == S_DATA) && w_last_edge) begin
                r_shift   <= {w_maj, r_shift[WIDTH-1:1]};
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : (r_bit_cnt + 1'b1);
            end

            if ((r_state == S_PARITY) && w_last_edge && (w_maj != w_exp_par)) begin
                r_par_fail <= 1'b1;
            end
        end
    end

    assign P_DATA       = r_p_data;
    assign data_valid   = r_data_valid;
    assign parity_error = r_parity_error;
    assign stop_error   = r_stop_error;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Oversampling UART receiver front end: it recovers frames from the serial line RX_IN and is the receive-side counterpart of the transmit path's parity generator. It detects the start bit and majority-samples each bit, shifting data in LSB first. It checks the optional parity bit using the same convention as the transmit side (type 0 = even, parity bit = XOR of data; type 1 = odd, parity bit = XNOR of data) and checks the stop bit. It delivers a parallel word with a one-cycle valid pulse, or an error pulse, toward the RX register file.

## Interface
- WIDTH, 8, number of data bits per frame
- CLK  input  1  oversampling clock; one clock; reset is synchronous and active-high
- RST  input  1  synchronous, active-high reset
- RX_IN  input  1  serial line, idle high, already synchronised to CLK
- prescale  input  6  oversampling ratio; legal values 8, 16, 32; any other value behaves as 8
- parity_enable  input  1  1 = frame carries a parity bit after the data bits
- parity_type  input  1  0 = even, 1 = odd
- P_DATA  output  WIDTH  last good received word
- data_valid  output  1  one-cycle pulse, P_DATA updated this cycle
- parity_error  output  1  one-cycle pulse, parity mismatch on the completed frame
- stop_error  output  1  one-cycle pulse, stop bit sampled low

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..P-1 within each bit, where P is the latched prescale. bit_cnt counts data bits 0..WIDTH-1.
- Latching at start detection: prescale, parity_enable and parity_type are latched in the cycle IDLE sees RX_IN==0. Changes mid-frame are ignored.
- IDLE: when RX_IN==0, that cycle is edge 0 of the start bit. Go to START with edge_cnt=1.
- Sampling: in every bit, RX_IN is captured at edges P/2-1, P/2 and P/2+1 (3,4,5 for P=8). The bit value is the majority of the three samples, committed at edge P-1.
- START, edge P-1: majority 1 is a glitch; return to IDLE with no output pulse. Majority 0 goes to DATA.
- DATA: the committed bit is shifted in LSB first. After bit WIDTH-1, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: expected parity = ^data when type is 0, ~^data when type is 1. A mismatch sets an internal parity-fail flag. Then go to STOP.
- STOP: at edge P-1, a majority of 0 sets stop-fail. The FSM returns to IDLE in all cases.
- Result cycle (the cycle after stop-bit edge P-1):
  - Neither flag set: P_DATA <= shifted word and data_valid=1.
  - Otherwise: P_DATA holds its old value. parity_error and/or stop_error pulse; both may pulse together.
  - data_valid never pulses alongside either error.
- After a stop_error, the line may still be low. IDLE treats this as a new start bit; the glitch filter rejects it if it is short.
- Reset: every output is 0 (P_DATA=0, all pulses 0), FSM goes to IDLE, and counters and flags clear. A reset mid-frame aborts the frame silently, with no pulse.

## Timing
- Frame length N = 1 + WIDTH + parity_enable + 1 bits.
- With start edge 0 at cycle 0, the stop bit's edge P-1 falls at cycle N*P-1. The result pulse is at cycle N*P. Example: WIDTH=8, parity on, P=8 gives N=11 and a pulse at cycle 88.
- All outputs are registered. Pulses are exactly one cycle wide.
- Back-to-back frames:
  - The result cycle is also an IDLE cycle. If RX_IN==0 there, it is edge 0 of the next start bit, so no gap bit is required.
  - Outputs of the previous frame are unaffected by this.
- RX_IN must stay stable at least through the three sample edges of each bit. Samples outside those edges are don't-care.

## Test plan
- P=8, parity on, even, frame 0xA5 with parity bit 0 and stop 1 -> data_valid at cycle 88, P_DATA=0xA5, no errors.
- P=16, parity on, odd, 0xA5 with parity bit 0 (wrong; correct is 1) -> parity_error pulse at cycle 176, data_valid 0, P_DATA unchanged.
- P=8, parity off, 0x3C with stop bit driven 0 -> stop_error at cycle 80. A second frame 0x81 sent after 2 idle bits -> data_valid, P_DATA=0x81.
- Glitch: RX_IN low for 3 cycles at P=8 -> START aborts at edge 7, no pulses. A following valid frame 0x55 is received correctly.
- Two back-to-back frames 0x01 then 0xFE at P=32, parity off, zero gap -> two data_valid pulses exactly 320 cycles apart, with values 0x01 then 0xFE.
- RST asserted for 1 cycle at cycle 40 of a frame -> no pulses, outputs 0. A frame started afterwards decodes correctly. prescale=5 behaves as 8.
